// File: rtl/pool_pkg.sv
// pool_pkg: shared types and helpers for the pool_max_stream engine.
//   - state_e      : engine state encoding (IDLE / RUN / DONE)
//   - cfg field    : cfg_data layout is {H[DIM_W], W[DIM_W], K[CFG_K_W]}
//   - smax()       : signed max of two channel values (callers sign-extend
//                    into SMAX_W bits and truncate the result back)
package pool_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // cfg_data field offsets; the H offset depends on the frame field width
    localparam int CFG_K_W   = 3;
    localparam int CFG_K_LSB = 0;
    localparam int CFG_W_LSB = CFG_K_W;

    function automatic int cfg_h_lsb(input int dim_w);
        return CFG_K_W + dim_w;
    endfunction

    // Channel values are widened to this width before comparison so one
    // function serves any DATA_W up to 32 bits.
    localparam int SMAX_W = 32;

    function automatic logic signed [SMAX_W-1:0] smax(
        input logic signed [SMAX_W-1:0] a,
        input logic signed [SMAX_W-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pool_line_buf.sv
// pool_line_buf: one-row line buffer holding partial vertical maxima, one
// entry per output column.
//   clk      : clock
//   wr_en    : write strobe
//   wr_addr  : write index (output column)
//   wr_data  : word to store
//   rd_addr  : read index (output column)
//   rd_data  : combinational read of entry rd_addr
// Contents are never cleared; every run overwrites an entry on its first
// window row before reading it.
module pool_line_buf #(
    parameter int WORD_W = 128,
    parameter int DEPTH  = 64,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [WORD_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [WORD_W-1:0] rd_data
);

    logic [WORD_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/pool_max_stream.sv
// pool_max_stream: streaming K x K (stride K) signed max-pool engine.
//   clk, rst_n          : clock, asynchronous active-low reset
//   pool_reset          : synchronous return to IDLE (line buffer kept)
//   cfg_val/cfg_rdy     : config handshake, cfg_data = {H, W, K}
//   in_val/in_rdy       : row-major pixel stream, in_data = CH_NUM channels
//   out_val/out_rdy     : pooled pixel stream, out_data + out_addr
//   fnh                 : one-cycle pulse when a run completes
//   out_flg             : (only with POOL_FLAG_EN) per-channel nonzero flags
// Optional feature macro: POOL_FLAG_EN.
module pool_max_stream
    import pool_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CH_NUM = 16,
    parameter int MAX_K  = 4,
    parameter int DIM_W  = 8,
    parameter int MAX_OW = 64,
    parameter int ADDR_W = 12,
    parameter int WORD_W = CH_NUM * DATA_W,
    parameter int CFG_W  = 2 * DIM_W + CFG_K_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pool_reset,
    input  logic              cfg_val,
    output logic              cfg_rdy,
    input  logic [CFG_W-1:0]  cfg_data,
    input  logic              in_val,
    output logic              in_rdy,
    input  logic [WORD_W-1:0] in_data,
    output logic              out_val,
    input  logic              out_rdy,
    output logic [WORD_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              fnh
`ifdef POOL_FLAG_EN
    ,
    output logic [CH_NUM-1:0] out_flg
`endif
);

    localparam int LB_AW    = $clog2(MAX_OW);
    localparam int CFG_H_LB = cfg_h_lsb(DIM_W);

    state_e state_q, state_d;
    logic                cfg_rdy_q;
    logic [CFG_K_W-1:0]  k_q, k_d;
    logic [DIM_W-1:0]    w_q, w_d, h_q, h_d;
    logic [DIM_W-1:0]    ow_q, ow_d, oh_q, oh_d;
    logic [DIM_W-1:0]    col_q, col_d, row_q, row_d;
    logic [DIM_W-1:0]    oc_q, oc_d, orow_q, orow_d;
    logic [CFG_K_W-1:0]  kx_q, kx_d, ky_q, ky_d;
    logic [WORD_W-1:0]   acc_q, acc_d;
    logic [WORD_W-1:0]   out_data_q, out_data_d;
    logic                out_val_q, out_val_d;
    logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
    logic                in_done_q, in_done_d;

    // ---------------- config decode ----------------
    logic [CFG_K_W-1:0] cfg_k_raw, cfg_k_eff;
    logic [DIM_W-1:0]   cfg_w, cfg_h, cfg_ow_full, cfg_ow, cfg_oh;

    assign cfg_k_raw = cfg_data[CFG_K_LSB +: CFG_K_W];
    assign cfg_w     = cfg_data[CFG_W_LSB +: DIM_W];
    assign cfg_h     = cfg_data[CFG_H_LB  +: DIM_W];

    always_comb begin
        if (cfg_k_raw == '0) begin
            cfg_k_eff = CFG_K_W'(1);
        end else if (int'(cfg_k_raw) > MAX_K) begin
            cfg_k_eff = CFG_K_W'(MAX_K);
        end else begin
            cfg_k_eff = cfg_k_raw;
        end
    end

    assign cfg_ow_full = cfg_w / DIM_W'(cfg_k_eff);
    assign cfg_ow      = (int'(cfg_ow_full) > MAX_OW) ? DIM_W'(MAX_OW) : cfg_ow_full;
    assign cfg_oh      = cfg_h / DIM_W'(cfg_k_eff);

    // ---------------- handshakes and window position ----------------
    logic cfg_fire, in_fire, out_fire, in_rdy_w;
    logic in_region, kx_last, ky_last, ky_first, col_last, row_last;
    logic win_col, win_done, inputs_done;

    assign cfg_fire = cfg_val && cfg_rdy_q;
    assign out_fire = out_val_q && out_rdy;
    assign in_rdy_w = (state_q == ST_RUN) && !(out_val_q && !out_rdy) && !in_done_q;
    assign in_fire  = in_val && in_rdy_w;

    // oc/orow stop advancing at OW/OH, so they double as the crop test for
    // columns >= OW*K and rows >= OH*K.
    assign in_region = (oc_q < ow_q) && (orow_q < oh_q);
    assign kx_last   = (kx_q == k_q - CFG_K_W'(1));
    assign ky_last   = (ky_q == k_q - CFG_K_W'(1));
    assign ky_first  = (ky_q == '0);
    assign col_last  = (col_q == w_q - DIM_W'(1));
    assign row_last  = (row_q == h_q - DIM_W'(1));

    assign win_col   = in_fire && in_region && kx_last;
    assign win_done  = win_col && ky_last;
    // Includes the cycle the final pixel is taken so fnh lines up with the
    // last output handshake even when trailing pixels are cropped.
    assign inputs_done = in_done_q || (in_fire && col_last && row_last);

    // ---------------- per-channel max datapath ----------------
    logic [WORD_W-1:0] hmax, vmax, merged, lb_rdata;

    genvar gi;
    generate
        for (gi = 0; gi < CH_NUM; gi++) begin : g_ch
            logic [DATA_W-1:0] pix_c, acc_c, lb_c, hmax_c;
            assign pix_c  = in_data[gi*DATA_W +: DATA_W];
            assign acc_c  = acc_q[gi*DATA_W +: DATA_W];
            assign lb_c   = lb_rdata[gi*DATA_W +: DATA_W];
            // First column of a window restarts the horizontal max.
            assign hmax_c = (kx_q == '0) ? pix_c :
                DATA_W'(smax(SMAX_W'(signed'(pix_c)), SMAX_W'(signed'(acc_c))));
            assign hmax[gi*DATA_W +: DATA_W] = hmax_c;
            assign vmax[gi*DATA_W +: DATA_W] =
                DATA_W'(smax(SMAX_W'(signed'(hmax_c)), SMAX_W'(signed'(lb_c))));
        end
    endgenerate

    // First window row has no earlier partial in the line buffer.
    assign merged = ky_first ? hmax : vmax;

    pool_line_buf #(
        .WORD_W (WORD_W),
        .DEPTH  (MAX_OW),
        .AW     (LB_AW)
    ) u_line_buf (
        .clk     (clk),
        .wr_en   (win_col && !ky_last),
        .wr_addr (oc_q[LB_AW-1:0]),
        .wr_data (merged),
        .rd_addr (oc_q[LB_AW-1:0]),
        .rd_data (lb_rdata)
    );

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        w_d        = w_q;
        h_d        = h_q;
        ow_d       = ow_q;
        oh_d       = oh_q;
        col_d      = col_q;
        row_d      = row_q;
        oc_d       = oc_q;
        orow_d     = orow_q;
        kx_d       = kx_q;
        ky_d       = ky_q;
        acc_d      = acc_q;
        out_data_d = out_data_q;
        out_val_d  = out_val_q;
        out_addr_d = out_addr_q;
        in_done_d  = in_done_q;

        if (out_fire) begin
            out_val_d  = 1'b0;
            out_addr_d = out_addr_q + ADDR_W'(1);
        end
        // A completion in the same cycle as a handshake reloads immediately.
        if (win_done) begin
            out_val_d  = 1'b1;
            out_data_d = merged;
        end

        case (state_q)
            ST_IDLE: begin
                if (cfg_fire) begin
                    k_d        = cfg_k_eff;
                    w_d        = cfg_w;
                    h_d        = cfg_h;
                    ow_d       = cfg_ow;
                    oh_d       = cfg_oh;
                    col_d      = '0;
                    row_d      = '0;
                    oc_d       = '0;
                    orow_d     = '0;
                    kx_d       = '0;
                    ky_d       = '0;
                    in_done_d  = 1'b0;
                    out_addr_d = '0;
                    state_d    = ((cfg_ow == '0) || (cfg_oh == '0)) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (in_fire) begin
                    if (in_region) begin
                        acc_d = hmax;
                    end
                    if (col_last) begin
                        col_d = '0;
                        kx_d  = '0;
                        oc_d  = '0;
                        row_d = row_q + DIM_W'(1);
                        if (ky_last) begin
                            ky_d   = '0;
                            orow_d = orow_q + DIM_W'(1);
                        end else begin
                            ky_d = ky_q + CFG_K_W'(1);
                        end
                        if (row_last) begin
                            in_done_d = 1'b1;
                        end
                    end else begin
                        col_d = col_q + DIM_W'(1);
                        if (in_region) begin
                            if (kx_last) begin
                                kx_d = '0;
                                oc_d = oc_q + DIM_W'(1);
                            end else begin
                                kx_d = kx_q + CFG_K_W'(1);
                            end
                        end
                    end
                end
                if (inputs_done && !win_done && (!out_val_q || out_rdy)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (pool_reset) begin
            state_d   = ST_IDLE;
            out_val_d = 1'b0;
        end
    end

    // ---------------- state registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cfg_rdy_q  <= 1'b0;
            k_q        <= '0;
            w_q        <= '0;
            h_q        <= '0;
            ow_q       <= '0;
            oh_q       <= '0;
            col_q      <= '0;
            row_q      <= '0;
            oc_q       <= '0;
            orow_q     <= '0;
            kx_q       <= '0;
            ky_q       <= '0;
            acc_q      <= '0;
            out_data_q <= '0;
            out_val_q  <= 1'b0;
            out_addr_q <= '0;
            in_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cfg_rdy_q  <= (state_d == ST_IDLE);
            k_q        <= k_d;
            w_q        <= w_d;
            h_q        <= h_d;
            ow_q       <= ow_d;
            oh_q       <= oh_d;
            col_q      <= col_d;
            row_q      <= row_d;
            oc_q       <= oc_d;
            orow_q     <= orow_d;
            kx_q       <= kx_d;
            ky_q       <= ky_d;
            acc_q      <= acc_d;
            out_data_q <= out_data_d;
            out_val_q  <= out_val_d;
            out_addr_q <= out_addr_d;
            in_done_q  <= in_done_d;
        end
    end

`ifdef POOL_FLAG_EN
    logic [CH_NUM-1:0] out_flg_q, out_flg_d;

    generate
        for (gi = 0; gi < CH_NUM; gi++) begin : g_flg
            assign out_flg_d[gi] = |out_data_d[gi*DATA_W +: DATA_W];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_flg_q <= '0;
        end else begin
            out_flg_q <= out_flg_d;
        end
    end

    assign out_flg = out_flg_q;
`endif

    assign cfg_rdy  = cfg_rdy_q;
    assign in_rdy   = in_rdy_w;
    assign out_val  = out_val_q;
    assign out_data = out_data_q;
    assign out_addr = out_addr_q;
    assign fnh      = (state_q == ST_DONE);

endmodule

// File: tb/tb_pool_max_stream.sv
module tb_pool_max_stream;

    localparam int DATA_W = 8;
    localparam int CH_NUM = 16;
    localparam int WORD_W = DATA_W * CH_NUM;
    localparam int DIM_W  = 8;
    localparam int ADDR_W = 12;
    localparam int CFG_W  = 2 * DIM_W + 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              pool_reset;
    logic              cfg_val;
    logic              cfg_rdy;
    logic [CFG_W-1:0]  cfg_data;
    logic              in_val;
    logic              in_rdy;
    logic [WORD_W-1:0] in_data;
    logic              out_val;
    logic              out_rdy;
    logic [WORD_W-1:0] out_data;
    logic [ADDR_W-1:0] out_addr;
    logic              fnh;
`ifdef POOL_FLAG_EN
    logic [CH_NUM-1:0] out_flg;
`endif

    always #5 clk = ~clk;

    pool_max_stream #(
        .DATA_W (DATA_W),
        .CH_NUM (CH_NUM),
        .MAX_K  (4),
        .DIM_W  (DIM_W),
        .MAX_OW (64),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pool_reset (pool_reset),
        .cfg_val    (cfg_val),
        .cfg_rdy    (cfg_rdy),
        .cfg_data   (cfg_data),
        .in_val     (in_val),
        .in_rdy     (in_rdy),
        .in_data    (in_data),
        .out_val    (out_val),
        .out_rdy    (out_rdy),
        .out_data   (out_data),
        .out_addr   (out_addr),
        .fnh        (fnh)
`ifdef POOL_FLAG_EN
        ,
        .out_flg    (out_flg)
`endif
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int n_out    = 0;
    int fnh_total   = 0;
    int fnh_cyc     = 0;
    int last_hs_cyc = 0;
    int cfg_cyc     = 0;
    int stalls      = 0;

    logic [WORD_W-1:0] got_data [0:63];
    logic [ADDR_W-1:0] got_addr [0:63];
`ifdef POOL_FLAG_EN
    logic [CH_NUM-1:0] got_flg  [0:63];
`endif

    // Output / event monitor, sampled on the falling edge.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && out_val && out_rdy) begin
            if (n_out < 64) begin
                got_data[n_out] <= out_data;
                got_addr[n_out] <= out_addr;
`ifdef POOL_FLAG_EN
                got_flg[n_out]  <= out_flg;
`endif
            end
            n_out       <= n_out + 1;
            last_hs_cyc <= cyc;
        end
        if (rst_n && fnh) begin
            fnh_total <= fnh_total + 1;
            fnh_cyc   <= cyc;
        end
        if (rst_n && cfg_val && cfg_rdy) begin
            cfg_cyc <= cyc;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    // Pixel patterns, one per scenario.
    function automatic logic [WORD_W-1:0] pix(input int pid, input int r, input int c, input int w);
        logic [WORD_W-1:0] v;
        logic [7:0]        b;
        int                idx;
        v   = '0;
        idx = r * w + c;
        case (pid)
            1: v[7:0] = 8'(idx);
            2: begin
                b = (r == 4 && c == 5) ? 8'h07 : 8'hFF;
                v = {CH_NUM{b}};
            end
            3: begin
                case (idx)
                    0:       b = 8'h80;
                    1:       b = 8'hFD;
                    2:       b = 8'hF9;
                    default: b = 8'h80;
                endcase
                v = {CH_NUM{b}};
            end
            5: begin
                v[7:0]            = 8'(idx - 3);
                v[WORD_W-1 -: 8]  = 8'(idx);
            end
            default: v = '0;
        endcase
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
        tick();
    endtask

    task automatic send_cfg(input logic [2:0] k, input logic [7:0] w, input logic [7:0] h);
        int t;
        t        = 0;
        cfg_data = {h, w, k};
        cfg_val  = 1'b1;
        @(negedge clk);
        while (!cfg_rdy && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!cfg_rdy) begin
            checks++;
            failures++;
            $display("FAIL cfg_timeout got cfg_rdy=%0b want 1", cfg_rdy);
        end
        tick();
        cfg_val = 1'b0;
    endtask

    task automatic send_px(input logic [WORD_W-1:0] d);
        int t;
        t       = 0;
        in_data = d;
        in_val  = 1'b1;
        @(negedge clk);
        while (!in_rdy && t < 200) begin
            stalls++;
            @(negedge clk);
            t++;
        end
        if (!in_rdy) begin
            checks++;
            failures++;
            $display("FAIL in_rdy_timeout got in_rdy=%0b want 1", in_rdy);
        end
        tick();
        in_val = 1'b0;
    endtask

    task automatic feed_frame(input int pid, input int w, input int h);
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                send_px(pix(pid, r, c, w));
            end
        end
    endtask

    task automatic wait_fnh();
        int t;
        t = 0;
        @(negedge clk);
        while (!fnh && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!fnh) begin
            checks++;
            failures++;
            $display("FAIL fnh_timeout got fnh=%0b want 1", fnh);
        end
        settle();
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        pool_reset = 1'b0;
        cfg_val    = 1'b0;
        cfg_data   = '0;
        in_val     = 1'b0;
        in_data    = '0;
        out_rdy    = 1'b1;
        repeat (2) @(negedge clk);
        checks += 6;
        if (cfg_rdy !== 1'b0) begin failures++; $display("FAIL reset_cfg_rdy got %b want 0", cfg_rdy); end
        if (in_rdy !== 1'b0) begin failures++; $display("FAIL reset_in_rdy got %b want 0", in_rdy); end
        if (out_val !== 1'b0) begin failures++; $display("FAIL reset_out_val got %b want 0", out_val); end
        if (out_data !== '0) begin failures++; $display("FAIL reset_out_data got %h want 0", out_data); end
        if (out_addr !== '0) begin failures++; $display("FAIL reset_out_addr got %h want 0", out_addr); end
        if (fnh !== 1'b0) begin failures++; $display("FAIL reset_fnh got %b want 0", fnh); end
        tick();
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (cfg_rdy !== 1'b1) begin failures++; $display("FAIL idle_cfg_rdy got %b want 1", cfg_rdy); end
        tick();
    endtask

    // K=2, W=4, H=4, channel 0 = pixel index; shared by basic and pool_reset tests.
    task automatic check_k2_frame(input string tag, input int base, input int fnh_base);
        logic [7:0]        e [4];
        logic [WORD_W-1:0] ew;
        e = '{8'd5, 8'd7, 8'd13, 8'd15};
        checks++;
        if (n_out - base !== 4) begin failures++; $display("FAIL %s_count got %0d want 4", tag, n_out - base); end
        for (int i = 0; i < 4; i++) begin
            ew      = '0;
            ew[7:0] = e[i];
            checks += 2;
            if (got_data[base+i] !== ew) begin failures++; $display("FAIL %s_data[%0d] got %h want %h", tag, i, got_data[base+i], ew); end
            if (got_addr[base+i] !== ADDR_W'(i)) begin failures++; $display("FAIL %s_addr[%0d] got %0d want %0d", tag, i, got_addr[base+i], i); end
`ifdef POOL_FLAG_EN
            checks++;
            if (got_flg[base+i] !== CH_NUM'(1)) begin failures++; $display("FAIL %s_flg[%0d] got %h want 0001", tag, i, got_flg[base+i]); end
`endif
            $display("%s out[%0d] addr=%0d data=%h", tag, i, got_addr[base+i], got_data[base+i]);
        end
        checks += 2;
        if (fnh_cyc !== last_hs_cyc + 1) begin failures++; $display("FAIL %s_fnh_timing got cyc %0d want %0d", tag, fnh_cyc, last_hs_cyc + 1); end
        if (fnh_total - fnh_base !== 1) begin failures++; $display("FAIL %s_fnh_pulses got %0d want 1", tag, fnh_total - fnh_base); end
    endtask

    task automatic test_basic();
        int base, fb;
        base = n_out;
        fb   = fnh_total;
        send_cfg(3'd2, 8'd4, 8'd4);
        feed_frame(1, 4, 4);
        wait_fnh();
        check_k2_frame("basic", base, fb);
    endtask

    task automatic test_discard();
        int base, st;
        logic [WORD_W-1:0] ew;
        base = n_out;
        st   = stalls;
        send_cfg(3'd3, 8'd7, 8'd6);
        feed_frame(2, 7, 6);
        wait_fnh();
        checks += 4;
        if (n_out - base !== 4) begin failures++; $display("FAIL discard_count got %0d want 4", n_out - base); end
        if (stalls - st !== 0) begin failures++; $display("FAIL discard_in_rdy_stalls got %0d want 0", stalls - st); end
        ew = {CH_NUM{8'hFF}};
        if (got_data[base] !== ew) begin failures++; $display("FAIL discard_data0 got %h want %h", got_data[base], ew); end
        ew = {CH_NUM{8'h07}};
        if (got_data[base+3] !== ew) begin failures++; $display("FAIL discard_data3 got %h want %h", got_data[base+3], ew); end
        $display("discard out[3] addr=%0d data=%h", got_addr[base+3], got_data[base+3]);
    endtask

    task automatic test_signed();
        int base;
        logic [WORD_W-1:0] ew;
        base = n_out;
        send_cfg(3'd2, 8'd2, 8'd2);
        feed_frame(3, 2, 2);
        wait_fnh();
        ew = {CH_NUM{8'hFD}};
        checks += 2;
        if (n_out - base !== 1) begin failures++; $display("FAIL signed_count got %0d want 1", n_out - base); end
        if (got_data[base] !== ew) begin failures++; $display("FAIL signed_data got %h want %h", got_data[base], ew); end
        $display("signed out[0] addr=%0d data=%h", got_addr[base], got_data[base]);
    endtask

    task automatic test_backpressure();
        int base;
        logic [7:0]        e [8];
        logic [WORD_W-1:0] ew;
        logic [WORD_W-1:0] hd;
        logic [ADDR_W-1:0] ha;
        logic have, unstable, leak;
        e        = '{8'd9, 8'd11, 8'd13, 8'd15, 8'd25, 8'd27, 8'd29, 8'd31};
        base     = n_out;
        have     = 1'b0;
        unstable = 1'b0;
        leak     = 1'b0;
        hd       = '0;
        ha       = '0;
        send_cfg(3'd2, 8'd8, 8'd4);
        fork
            feed_frame(1, 8, 4);
            begin
                int t;
                t = 0;
                while (n_out < base + 2 && t < 500) begin
                    @(negedge clk);
                    t++;
                end
                tick();
                out_rdy = 1'b0;
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    if (out_val) begin
                        if (!have) begin
                            hd   = out_data;
                            ha   = out_addr;
                            have = 1'b1;
                        end else if (out_data !== hd || out_addr !== ha) begin
                            unstable = 1'b1;
                        end
                        if (in_rdy) leak = 1'b1;
                    end
                end
                tick();
                out_rdy = 1'b1;
            end
        join
        wait_fnh();
        checks += 4;
        if (have !== 1'b1) begin failures++; $display("FAIL bp_held got out_val seen=%b want 1", have); end
        if (unstable !== 1'b0) begin failures++; $display("FAIL bp_stable got changed=%b want 0", unstable); end
        if (leak !== 1'b0) begin failures++; $display("FAIL bp_in_rdy got high=%b want 0", leak); end
        if (n_out - base !== 8) begin failures++; $display("FAIL bp_count got %0d want 8", n_out - base); end
        for (int i = 0; i < 8; i++) begin
            ew      = '0;
            ew[7:0] = e[i];
            checks += 2;
            if (got_data[base+i] !== ew) begin failures++; $display("FAIL bp_data[%0d] got %h want %h", i, got_data[base+i], ew); end
            if (got_addr[base+i] !== ADDR_W'(i)) begin failures++; $display("FAIL bp_addr[%0d] got %0d want %0d", i, got_addr[base+i], i); end
            $display("bp out[%0d] addr=%0d data=%h", i, got_addr[base+i], got_data[base+i]);
        end
    endtask

    task automatic test_k_clamp();
        int base, fb;
        logic [WORD_W-1:0] ew;
        base = n_out;
        send_cfg(3'd0, 8'd3, 8'd2);
        feed_frame(5, 3, 2);
        wait_fnh();
        checks++;
        if (n_out - base !== 6) begin failures++; $display("FAIL k0_count got %0d want 6", n_out - base); end
        for (int i = 0; i < 6; i++) begin
            ew = pix(5, i / 3, i % 3, 3);
            checks += 2;
            if (got_data[base+i] !== ew) begin failures++; $display("FAIL k0_data[%0d] got %h want %h", i, got_data[base+i], ew); end
            if (got_addr[base+i] !== ADDR_W'(i)) begin failures++; $display("FAIL k0_addr[%0d] got %0d want %0d", i, got_addr[base+i], i); end
            $display("k0 out[%0d] addr=%0d data=%h", i, got_addr[base+i], got_data[base+i]);
        end
        // W=1 with K=2 leaves no output columns: straight to DONE.
        base = n_out;
        fb   = fnh_total;
        send_cfg(3'd2, 8'd1, 8'd4);
        wait_fnh();
        checks += 3;
        if (n_out - base !== 0) begin failures++; $display("FAIL empty_count got %0d want 0", n_out - base); end
        if (fnh_cyc !== cfg_cyc + 1) begin failures++; $display("FAIL empty_fnh_timing got cyc %0d want %0d", fnh_cyc, cfg_cyc + 1); end
        if (fnh_total - fb !== 1) begin failures++; $display("FAIL empty_fnh_pulses got %0d want 1", fnh_total - fb); end
        $display("empty run fnh at cycle %0d cfg at %0d", fnh_cyc, cfg_cyc);
    endtask

    task automatic test_pool_reset();
        int base, fb;
        send_cfg(3'd2, 8'd4, 8'd4);
        for (int i = 0; i < 6; i++) begin
            send_px(pix(1, i / 4, i % 4, 4));
        end
        pool_reset = 1'b1;
        tick();
        pool_reset = 1'b0;
        @(negedge clk);
        checks += 3;
        if (cfg_rdy !== 1'b1) begin failures++; $display("FAIL preset_cfg_rdy got %b want 1", cfg_rdy); end
        if (out_val !== 1'b0) begin failures++; $display("FAIL preset_out_val got %b want 0", out_val); end
        if (in_rdy !== 1'b0) begin failures++; $display("FAIL preset_in_rdy got %b want 0", in_rdy); end
        settle();
        base = n_out;
        fb   = fnh_total;
        send_cfg(3'd2, 8'd4, 8'd4);
        feed_frame(1, 4, 4);
        wait_fnh();
        check_k2_frame("rerun", base, fb);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_discard();
        test_signed();
        test_backpressure();
        test_k_clamp();
        test_pool_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pool_max_stream.md
# pool_max_stream

Parametrised streaming max-pool engine, the successor to the fixed `POOL` block. It takes row-major activation words, each carrying CH_NUM signed channels, from the global buffer over a valid/ready stream. It computes a signed max over a configurable K×K window with stride K and writes one pooled word per window toward the buffer side, along with a linear output address. Window size and frame dimensions are set per run through a config handshake.

## Interface
- DATA_W, 8, bits per channel, signed two's complement
- CH_NUM, 16, channels per word; word width WORD_W = CH_NUM*DATA_W
- MAX_K, 4, largest window/stride supported
- DIM_W, 8, width of frame width/height fields
- MAX_OW, 64, line-buffer depth (maximum output columns)
- ADDR_W, 12, output address width
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- pool_reset  in  1  synchronous clear to IDLE; line buffer contents are not cleared
- cfg_val / cfg_rdy  in/out  1  config handshake
- cfg_data  in  2*DIM_W+3  {H[DIM_W], W[DIM_W], K[3]}
- in_val / in_rdy  in/out  1  activation stream handshake
- in_data  in  WORD_W  one pixel, all channels
- out_val / out_rdy  out/in  1  pooled stream handshake
- out_data  out  WORD_W  pooled pixel
- out_addr  out  ADDR_W  linear output index, 0-based per run
- fnh  out  1  one-cycle pulse at end of run

## Operation
- States: IDLE → RUN → DONE → IDLE. `pool_reset` forces IDLE from any state and drops `out_val`.
- IDLE:
  - cfg_rdy=1.
  - On a cfg handshake, latch K, W and H.
  - K=0 is treated as 1; K>MAX_K is clamped to MAX_K.
  - OW = min(floor(W/K), MAX_OW); OH = floor(H/K).
  - If OW=0 or OH=0, go to DONE. Otherwise go to RUN.
- RUN:
  - Counters: col (0..W-1), row (0..H-1), kx, ky (0..K-1), oc (0..OW-1).
  - Each accepted pixel is max-combined per channel into a horizontal accumulator.
  - When kx=K-1, the accumulator merges with line buffer entry oc:
    - ky=0: write the accumulator.
    - 0<ky<K-1: write the max of accumulator and entry.
    - ky=K-1: load max(acc, entry) into the output register and set out_val.
  - Pixels at col ≥ OW*K or row ≥ OH*K are accepted and discarded.
  - After the last input pixel (row=H-1, col=W-1) is accepted and the final output has been accepted, go to DONE.
- DONE: fnh=1 for one cycle, then IDLE.
- Max is signed per channel and has no width growth.
- out_addr increments by 1 on each output handshake and clears on each cfg handshake.

## Timing
- Reset values: cfg_rdy=0 while rst_n is low, 1 in IDLE after reset release; in_rdy=0, out_val=0, out_data=0, out_addr=0, fnh=0.
- in_rdy = (state==RUN) && !(out_val && !out_rdy) && inputs remaining.
- out_val asserts the cycle after the window's last pixel is accepted (latency 1). It holds with stable data and address until out_rdy is high.
- If an output handshake and a new window completion happen in the same cycle, the new value loads with no bubble. Sustained throughput is 1 pixel/cycle.
- fnh fires exactly one cycle after the last output handshake. With OW or OH equal to 0, it fires one cycle after the cfg handshake.
- in_val while not in RUN is ignored. cfg_val outside IDLE is ignored.

## Configuration
- `POOL_FLAG_EN` defined:
  - Adds output `out_flg` (CH_NUM bits), bit c = (channel c of out_data != 0).
  - out_flg is registered alongside out_data, shares out_val/out_rdy, and resets to 0.
- Not defined: the port and its logic are absent; all other behaviour is identical.

## Structure
- Package `pool_pkg`:
  - state enum.
  - cfg field offsets and the K field width (3).
  - per-channel signed-max function.
- Sub-module `pool_line_buf`: MAX_OW × WORD_W register array, synchronous write, combinational read, with one write port and one read port addressed by oc.

## Test plan
- K=2, W=4, H=4, one channel value = pixel index 0..15, others 0, out_rdy=1 → 4 outputs with values 5, 7, 13, 15 at addr 0–3, then fnh one cycle after addr 3.
- K=3, W=7, H=6, all channels −1 except the pixel at row 4, col 5 set to 7 → OW=2, OH=2. Last output (addr 3) channels = 7. Columns 6 and rows beyond 5 are discarded, and in_rdy stays high for them.
- Signed check, K=2, window {−128, −3, −7, −128} → output −3 (0xFD).
- Back-pressure: out_rdy low for 10 cycles mid-run → in_rdy drops, out_data/out_addr stay stable, no window is lost, total output count = OW*OH.
- cfg with K=0, W=3, H=2 → behaves as K=1 and produces 6 pass-through outputs. cfg with W=1, K=2 → no outputs, fnh 1 cycle after cfg.
- pool_reset asserted mid-run → next cycle state is IDLE, out_val=0, cfg_rdy=1. The following run has the same outputs as a fresh run. With POOL_FLAG_EN, out_flg matches the nonzero channels of every output.
